nn_reset_sequencer: RTL



---
 rtl/nn_reset_sequencer_pkg.sv | 24 ++
 rtl/nn_delay_counter.sv | 35 +++
 rtl/nn_reset_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/nn_reset_sequencer_pkg.sv
// Shared FSM encoding and default timing constants for the multi-domain reset sequencer.
package nn_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        StHold    = 3'd0,
        StGap     = 3'd1,
        StWaitAck = 3'd2,
        StDone    = 3'd3,
        StFault   = 3'd4
    } seq_state_e;

    localparam int unsigned DefNch        = 4;
    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefHoldCycles = 10;
    localparam int unsigned DefStageGap   = 8;
    localparam int unsigned DefAckTimeout = 64;
    localparam logic [DefNch-1:0] DefAckMask = 4'b0100;

    // A single-stage build still needs a 1-bit stage port.
    function automatic int unsigned stage_idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_delay_counter.sv
// Up counter with synchronous clear/enable and a terminal-count compare against a live input.
module nn_delay_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/nn_reset_sequencer.sv
// Multi-domain reset sequencer: holds all resets until lock plus a hold count, then releases
// stages in index order, each after a fixed gap or a consumer ack (with timeout to FAULT).
module nn_reset_sequencer
    import nn_reset_sequencer_pkg::*;
#(
    parameter int unsigned       NCH         = DefNch,
    parameter int unsigned       CNT_W       = DefCntW,
    parameter int unsigned       HOLD_CYCLES = DefHoldCycles,
    parameter int unsigned       STAGE_GAP   = DefStageGap,
    parameter logic [NCH-1:0]    ACK_MASK    = DefAckMask,
    parameter int unsigned       ACK_TIMEOUT = DefAckTimeout,
    localparam int unsigned      SW          = stage_idx_w(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           lock,
    input  logic           sw_req,
    input  logic [NCH-1:0] stage_ack,
    output logic [NCH-1:0] rst_out,
    output logic           done,
    output logic           fault,
    output logic [SW-1:0]  stage
);

    seq_state_e     state_q;
    logic [NCH-1:0] rst_out_q;
    logic           done_q;
    logic           fault_q;
    logic [SW-1:0]  stage_q;

    logic [CNT_W-1:0] cnt_term;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

    logic          restart;
    logic          hold_done;
    logic          stage_done;
    logic          timeout;
    logic          cur_ack;
    logic [SW-1:0] next_stage;

    // Lock loss only restarts once something has been released; FAULT ignores it.
    assign restart    = sw_req | (~lock & (state_q inside {StGap, StWaitAck, StDone}));
    assign cur_ack    = stage_ack[stage_q];
    assign next_stage = stage_q + 1'b1;
    assign hold_done  = (state_q == StHold) & lock & cnt_tc;
    assign timeout    = (state_q == StWaitAck) & cnt_tc;
    assign stage_done = ((state_q == StGap) & cnt_tc) | ((state_q == StWaitAck) & ~cnt_tc & cur_ack);

    always_comb begin
        cnt_term = '0;
        case (state_q)
            StHold:    cnt_term = CNT_W'(HOLD_CYCLES - 1);
            StGap:     cnt_term = CNT_W'(STAGE_GAP - 1);
            StWaitAck: cnt_term = CNT_W'(ACK_TIMEOUT - 1);
            default:   cnt_term = '0;
        endcase
    end

    always_comb begin
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        if (!restart) begin
            case (state_q)
                StHold: begin
                    cnt_clr = ~lock | cnt_tc;
                    cnt_en  = lock;
                end
                StGap: begin
                    cnt_clr = cnt_tc;
                    cnt_en  = 1'b1;
                end
                StWaitAck: begin
                    cnt_clr = cnt_tc | cur_ack;
                    cnt_en  = 1'b1;
                end
                default: begin
                    cnt_clr = 1'b1;
                    cnt_en  = 1'b0;
                end
            endcase
        end
    end

    nn_delay_counter #(
        .CNT_W(CNT_W)
    ) u_delay_counter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .tc_o   (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StHold;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            stage_q   <= '0;
        end else if (restart) begin
            state_q   <= StHold;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            stage_q   <= '0;
            if (sw_req) begin
                fault_q <= 1'b0;
            end
        end else if (hold_done) begin
            rst_out_q[0] <= 1'b0;
            stage_q      <= '0;
            state_q      <= ACK_MASK[0] ? StWaitAck : StGap;
        end else if (timeout) begin
            state_q   <= StFault;
            rst_out_q <= '1;
            fault_q   <= 1'b1;
            done_q    <= 1'b0;
        end else if (stage_done) begin
            if (stage_q == SW'(NCH - 1)) begin
                state_q   <= StDone;
                rst_out_q <= '0;
                done_q    <= 1'b1;
            end else begin
                stage_q               <= next_stage;
                rst_out_q[next_stage] <= 1'b0;
                state_q               <= ACK_MASK[next_stage] ? StWaitAck : StGap;
            end
        end
    end

    assign rst_out = rst_out_q;
    assign done    = done_q;
    assign fault   = fault_q;
    assign stage   = stage_q;

endmodule
